pattern_counter: RTL

PATTERN_COUNTER -- requirements
Module: pattern_counter

---
 rtl/pattern_counter_pkg.sv | 36 +++
 rtl/pattern_step.sv | 35 +++
 rtl/pattern_counter.sv | 106 ++++++++++
 3 files changed

// File: rtl/pattern_counter_pkg.sv
// pattern_counter_pkg
//    Shared definitions for the pattern counter: the sequence-select enum
//    and the per-mode seed and terminal values.
//    Both helpers return a 32-bit value; callers size-cast the result down to
//    their own counter width, which keeps the functions independent of WIDTH.
package pattern_counter_pkg;

   typedef enum logic [1:0] {
      THERMO  = 2'd0,
      ODD     = 2'd1,
      BIN     = 2'd2,
      JOHNSON = 2'd3
   } mode_e;

   localparam int unsigned MaxWidth = 32;

   // First value of each sequence: ODD starts at 1 so it stays odd, all
   // other modes start from zero.
   function automatic logic [MaxWidth-1:0] seedValue(input mode_e mode);
      seedValue = (mode == ODD) ? 32'd1 : 32'd0;
   endfunction

   // Last value of each sequence for a counter of the given width.
   // JOHNSON ends on the single-MSB pattern; the other modes end on all-ones.
   function automatic logic [MaxWidth-1:0] terminalValue(input mode_e mode,
                                                         input int unsigned width);
      logic [MaxWidth-1:0] ones;
      ones = (width >= MaxWidth) ? '1 : ((32'd1 << width) - 32'd1);
      if (mode == JOHNSON) begin
         terminalValue = 32'd1 << (width - 1);
      end else begin
         terminalValue = ones;
      end
   endfunction

endpackage

// File: rtl/pattern_step.sv
// pattern_step
//    Purely combinational next-value generator for the pattern counter.
//    Ports:
//       cnt_i   current counter value
//       mode_i  active sequence
//       next_o  value one step further along the sequence (truncated to WIDTH)
//       term_o  high when cnt_i is the terminal value of mode_i
//    Off-sequence values are stepped by the same rule with no correction.
module pattern_step
   import pattern_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cnt_i,
   input  mode_e            mode_i,
   output logic [WIDTH-1:0] next_o,
   output logic             term_o
);

   // One step of each sequence. THERMO shifts a one in from the bottom,
   // JOHNSON shifts in the inverted MSB (twisted ring).
   always_comb begin
      next_o = cnt_i;
      case (mode_i)
         THERMO:  next_o = {cnt_i[WIDTH-2:0], 1'b1};
         ODD:     next_o = cnt_i + WIDTH'(2);
         BIN:     next_o = cnt_i + WIDTH'(1);
         JOHNSON: next_o = {cnt_i[WIDTH-2:0], ~cnt_i[WIDTH-1]};
         default: next_o = cnt_i;
      endcase
   end

   assign term_o = (cnt_i == WIDTH'(terminalValue(mode_i, WIDTH)));

endmodule

// File: rtl/pattern_counter.sv
// pattern_counter
//    Multi-mode sequence counter (thermometer, odd, binary, Johnson) with
//    load, optional wrap-around and saturation indication.
//    Ports:
//       clk       single clock, rising edge
//       reset_n   synchronous active-low reset
//       en        advance one step this cycle
//       mode      sequence select (0 THERMO, 1 ODD, 2 BIN, 3 JOHNSON)
//       load      load load_val this cycle
//       load_val  value to load (bit 0 forced high in ODD mode)
//       wrap_en   1: restart at seed after terminal, 0: hold at terminal
//       cnt_o     current value, straight from a register
//       wrap_o    one-cycle pulse the cycle after a terminal-to-seed restart
//       sat_o     counter parked at terminal with wrapping disabled
//    Priority each cycle: reset, mode change, load, step, hold.
module pattern_counter
   import pattern_counter_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter bit WRAP_DEFAULT = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             wrap_en,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o,
   output logic             sat_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   mode_e            mode_q, mode_d;
   logic             wrap_q, wrap_d;

   mode_e            modeReq;
   logic [WIDTH-1:0] stepValue;
   logic             atTerminal;

   // WRAP_DEFAULT only tells integrators what to tie wrap_en to; the
   // counter itself always follows the wrap_en pin.
   logic             unusedWrapDefault;
   assign unusedWrapDefault = WRAP_DEFAULT;

   assign modeReq = mode_e'(mode);

   // The step is always taken along the registered mode, never the
   // incoming one, since a mode change overrides stepping anyway.
   pattern_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .cnt_i  (cnt_q),
      .mode_i (mode_q),
      .next_o (stepValue),
      .term_o (atTerminal)
   );

   // Next-state selection in priority order. A mode change reseeds and
   // swallows any load or step requested in the same cycle. A load never
   // produces a wrap pulse, even when it lands on or leaves the terminal.
   always_comb begin
      cnt_d  = cnt_q;
      mode_d = mode_q;
      wrap_d = 1'b0;
      if (modeReq != mode_q) begin
         cnt_d  = WIDTH'(seedValue(modeReq));
         mode_d = modeReq;
      end else if (load) begin
         cnt_d = load_val;
         if (mode_q == ODD) begin
            cnt_d[0] = 1'b1;
         end
      end else if (en) begin
         if (!atTerminal) begin
            cnt_d = stepValue;
         end else if (wrap_en) begin
            cnt_d  = WIDTH'(seedValue(mode_q));
            wrap_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset; reset also kills a wrap pulse
   // that would otherwise appear in the following cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         mode_q <= THERMO;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = wrap_q;

   // Saturation only means something while the mode is stable; a pending
   // mode change will reseed the counter on the next edge.
   assign sat_o = atTerminal && (modeReq == mode_q) && !wrap_en;

endmodule
